fifo_buffer: RTL and testbench



---
 rtl/fifo_buffer_ram.sv | 17 +
 rtl/fifo_buffer.sv | 42 ++++
 tb/tb_fifo_buffer.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/fifo_buffer_ram.sv
// fifo_buffer_ram: simple dual-port memory, synchronous write, asynchronous read
module fifo_buffer_ram #(
  parameter int abits = 7,
  parameter int dbits = 64
) (
  input  logic             clock,
  input  logic             we,
  input  logic [abits-1:0] waddr,
  input  logic [dbits-1:0] wdata,
  input  logic [abits-1:0] raddr,
  output logic [dbits-1:0] rdata
);
  logic [dbits-1:0] mem [2**abits];
  always_ff @(posedge clock)
    if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/fifo_buffer.sv
// fifo_buffer: first-word-fall-through circular FIFO with stream handshakes on both sides
module fifo_buffer #(
  parameter int abits = 7,
  parameter int dbits = 64
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [dbits-1:0] din,
  input  logic             s_axis_tvalid,
  output logic             s_axis_tready,
  output logic [dbits-1:0] dout,
  output logic             m_axis_tvalid,
  input  logic             m_axis_tready
);
  logic [abits:0]   wr_ptr, rd_ptr;
  logic [dbits-1:0] rdata;
  logic             empty, full, wr, rd;
  // the extra MSB on each pointer tells full from empty when the low bits match
  assign empty         = wr_ptr == rd_ptr;
  assign full          = (wr_ptr[abits-1:0] == rd_ptr[abits-1:0]) && (wr_ptr[abits] != rd_ptr[abits]);
  assign s_axis_tready = !full && !reset;
  assign m_axis_tvalid = !empty;
  assign wr            = s_axis_tvalid && s_axis_tready;
  assign rd            = m_axis_tvalid && m_axis_tready;
  assign dout          = empty ? '0 : rdata;
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr) wr_ptr <= wr_ptr + 1'b1;
      if (rd) rd_ptr <= rd_ptr + 1'b1;
    end
  fifo_buffer_ram #(.abits(abits), .dbits(dbits)) u_ram (
    .clock (clock),
    .we    (wr),
    .waddr (wr_ptr[abits-1:0]),
    .wdata (din),
    .raddr (rd_ptr[abits-1:0]),
    .rdata (rdata)
  );
endmodule

// File: tb/tb_fifo_buffer.sv
// tb_fifo_buffer: directed stimulus with a queue scoreboard checked by an independent monitor
module tb_fifo_buffer;
  localparam int DEPTH = 128;
  logic        clock = 0, reset = 1;
  logic [63:0] din = '0;
  logic        s_axis_tvalid = 0, m_axis_tready = 0;
  logic        s_axis_tready, m_axis_tvalid;
  logic [63:0] dout;
  logic [63:0] q[$];
  logic [63:0] burst [6] = '{64'h0000000100000001, 64'h0000000100000002, 64'h0000000100000003,
                             64'h0000000100000004, 64'h0000000200000003, 64'h0000000200000004};
  int errors = 0, checks = 0, reads = 0, r0;

  always #5 clock = ~clock;

  fifo_buffer #(.abits(7), .dbits(64)) dut (
    .clock         (clock),
    .reset         (reset),
    .din           (din),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .dout          (dout),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // reference model: occupancy and contents derived only from the stimulus
  always @(posedge clock or posedge reset) begin : model
    bit do_rd, do_wr;
    if (reset) q.delete();
    else begin
      do_rd = m_axis_tready && q.size() > 0;
      do_wr = s_axis_tvalid && q.size() < DEPTH;
      if (do_rd) begin
        void'(q.pop_front());
        reads++;
      end
      if (do_wr) q.push_back(din);
    end
  end

  always @(negedge clock) begin
    check("tvalid", {63'd0, m_axis_tvalid}, {63'd0, q.size() != 0});
    check("tready", {63'd0, s_axis_tready}, {63'd0, !reset && q.size() < DEPTH});
    check("dout", dout, q.size() != 0 ? q[0] : 64'd0);
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  initial begin
    repeat (10) step();
    check("reset_tvalid", {63'd0, m_axis_tvalid}, 64'd0);
    check("reset_dout", dout, 64'd0);
    reset = 0;
    #1;
    check("post_reset_tready", {63'd0, s_axis_tready}, 64'd1);
    check("post_reset_tvalid", {63'd0, m_axis_tvalid}, 64'd0);
    s_axis_tvalid = 1;
    for (int w = 0; w < 6; w++) begin
      din = burst[w];
      repeat (10) step();
    end
    s_axis_tvalid = 0;
    check("burst_head", dout, 64'h0000000100000001);
    check("burst_tready", {63'd0, s_axis_tready}, 64'd1);
    r0 = reads;
    m_axis_tready = 1;
    repeat (59) step();
    check("drain_last_word", dout, 64'h0000000200000004);
    check("drain_tvalid_before_last", {63'd0, m_axis_tvalid}, 64'd1);
    step();
    m_axis_tready = 0;
    check("drain_count", reads - r0, 64'd60);
    check("drain_empty", {63'd0, m_axis_tvalid}, 64'd0);
    s_axis_tvalid = 1;
    for (int i = 0; i < DEPTH; i++) begin
      din = 64'h1000 + 64'(i);
      step();
    end
    check("full_tready", {63'd0, s_axis_tready}, 64'd0);
    din = 64'hDEAD;
    step();
    s_axis_tvalid = 0;
    check("full_head", dout, 64'h1000);
    m_axis_tready = 1;
    step();
    m_axis_tready = 0;
    check("full_read_tready", {63'd0, s_axis_tready}, 64'd1);
    check("full_read_head", dout, 64'h1001);
    r0 = reads;
    m_axis_tready = 1;
    repeat (127) step();
    m_axis_tready = 0;
    check("full_drain_count", reads - r0, 64'd127);
    check("full_drain_empty", {63'd0, m_axis_tvalid}, 64'd0);
    s_axis_tvalid = 1;
    for (int i = 0; i < 64; i++) begin
      din = 64'h2000 + 64'(i);
      step();
    end
    r0 = reads;
    m_axis_tready = 1;
    for (int i = 0; i < 200; i++) begin
      din = 64'h3000 + 64'(i);
      step();
    end
    s_axis_tvalid = 0;
    m_axis_tready = 0;
    check("steady_reads", reads - r0, 64'd200);
    check("steady_head", dout, 64'h3000 + 64'd136);
    check("steady_tready", {63'd0, s_axis_tready}, 64'd1);
    m_axis_tready = 1;
    repeat (64) step();
    m_axis_tready = 0;
    check("steady_empty", {63'd0, m_axis_tvalid}, 64'd0);
    s_axis_tvalid = 1;
    for (int i = 0; i < 10; i++) begin
      din = 64'h4000 + 64'(i);
      step();
    end
    s_axis_tvalid = 0;
    check("pre_reset_head", dout, 64'h4000);
    #2 reset = 1;
    #1;
    check("async_reset_tvalid", {63'd0, m_axis_tvalid}, 64'd0);
    check("async_reset_tready", {63'd0, s_axis_tready}, 64'd0);
    check("async_reset_dout", dout, 64'd0);
    repeat (2) step();
    reset = 0;
    din = 64'h1234;
    s_axis_tvalid = 1;
    step();
    s_axis_tvalid = 0;
    check("post_reset_write_tvalid", {63'd0, m_axis_tvalid}, 64'd1);
    check("post_reset_write_dout", dout, 64'h1234);
    step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "timeout");
  end
endmodule
